// File: rtl/ibex_avalon_data_bridge.sv
// Ibex data port to Avalon-MM host bridge with an in-order tracker.
// Ports: clk_i/rst_ni, cpu_* core side, avm_* Avalon host side, err_unexpected_o.
module ibex_avalon_data_bridge #(
  parameter int MAX_OUTST = 2,
  parameter bit AV_WRESP  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  cpu_resp,
  output logic        cpu_wrespvalid,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic [1:0]  avm_response,
  input  logic        avm_writeresponsevalid,
  output logic        err_unexpected_o
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  typedef logic [PW-1:0] ptr_t;

  logic        is_wr_q [MAX_OUTST];
  logic        done_q  [MAX_OUTST];
  logic [31:0] rdata_q [MAX_OUTST];
  logic [1:0]  resp_q  [MAX_OUTST];

  ptr_t        head, tail, cidx;
  logic [2:0]  count;
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;
  logic        err_q;

  logic full, accept, pop;
  logic rsp_rd, rsp_wr, rsp_any;
  logic found, complete, bad;
  int   j;

  function automatic ptr_t nxt(input ptr_t p);
    return (p == ptr_t'(MAX_OUTST - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full = (count == 3'(MAX_OUTST));

  // Read wins over write when the core raises both.
  assign avm_read  = rst_ni & cpu_read & ~full;
  assign avm_write = rst_ni & cpu_write & ~cpu_read & ~full;
  assign avm_address    = cpu_addr;
  assign avm_byteenable = cpu_be;
  assign avm_writedata  = cpu_wdata;
  assign cpu_busy = ~rst_ni | avm_waitrequest | full;

  assign accept = (avm_read | avm_write) & ~avm_waitrequest;
  assign pop    = rst_ni & (count != 3'd0) & done_q[head];

  assign cpu_rvalid     = pop & ~is_wr_q[head];
  assign cpu_wrespvalid = pop & is_wr_q[head];
  assign cpu_rdata = pop ? rdata_q[head] : last_rdata;
  assign cpu_resp  = pop ? resp_q[head]  : last_resp;
  assign err_unexpected_o = err_q;

  assign rsp_rd  = avm_readdatavalid;
  assign rsp_wr  = AV_WRESP & avm_writeresponsevalid;
  assign rsp_any = rsp_rd | rsp_wr;

  // Oldest live entry still waiting for its response.
  always_comb begin
    found = 1'b0;
    cidx  = '0;
    j     = 0;
    for (int i = 0; i < MAX_OUTST; i++) begin
      j = (int'(head) + i) % MAX_OUTST;
      if (!found && i < int'(count) && !done_q[j]) begin
        found = 1'b1;
        cidx  = ptr_t'(j);
      end
    end
  end

  // Both response strobes at once is a protocol violation: flag it.
  assign complete = rsp_any & ~(rsp_rd & rsp_wr) & found
                  & (is_wr_q[cidx] == rsp_wr);
  assign bad = rsp_any & ~complete;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      err_q      <= 1'b0;
      last_rdata <= '0;
      last_resp  <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        is_wr_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
        rdata_q[i] <= '0;
        resp_q[i]  <= '0;
      end
    end else begin
      if (accept) begin
        is_wr_q[tail] <= avm_write;
        done_q[tail]  <= avm_write & ~AV_WRESP;
        rdata_q[tail] <= '0;
        resp_q[tail]  <= '0;
        tail          <= nxt(tail);
      end
      if (complete) begin
        done_q[cidx] <= 1'b1;
        resp_q[cidx] <= avm_response;
        if (!rsp_wr) rdata_q[cidx] <= avm_readdata;
      end
      if (pop) begin
        head       <= nxt(head);
        last_rdata <= rdata_q[head];
        last_resp  <= resp_q[head];
      end
      count <= count + 3'(accept) - 3'(pop);
      if (bad) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_avalon_data_bridge.sv
// Scoreboard bench for ibex_avalon_data_bridge (MAX_OUTST=2, AV_WRESP=0).
// Expected deliveries are queued at issue and checked as they pop out.
module tb_ibex_avalon_data_bridge;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_busy, cpu_rvalid, cpu_wrespvalid;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_resp;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [1:0]  avm_response;
  logic        avm_writeresponsevalid;
  logic        err_unexpected_o;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ibex_avalon_data_bridge #(.MAX_OUTST(2), .AV_WRESP(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp),
    .cpu_wrespvalid(cpu_wrespvalid), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_response(avm_response),
    .avm_writeresponsevalid(avm_writeresponsevalid),
    .err_unexpected_o(err_unexpected_o)
  );

  // Negedge sample: any delivery is checked against the scoreboard head.
  task automatic mid();
    exp_t e;
    @(negedge clk);
    if (cpu_rvalid && cpu_wrespvalid) begin
      tests++; fails++;
      $display("FAIL overlap rvalid=1 wrespvalid=1 want one-hot");
    end else if (cpu_rvalid || cpu_wrespvalid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL stray_delivery rvalid=%0b wresp=%0b want none",
                 cpu_rvalid, cpu_wrespvalid);
      end else begin
        e = sb.pop_front();
        if (cpu_wrespvalid !== e.w || cpu_resp !== e.r ||
            (!e.w && cpu_rdata !== e.d)) begin
          fails++;
          $display("FAIL delivery got w=%0b d=%h r=%0d want w=%0b d=%h r=%0d",
                   cpu_wrespvalid, cpu_rdata, cpu_resp, e.w, e.d, e.r);
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    cpu_read = 1'b1;
    mid();
    tests++;
    if (cpu_busy !== 1'b1 || avm_read !== 1'b0) begin
      fails++;
      $display("FAIL reset_gate busy=%0b rd=%0b want 1 0", cpu_busy, avm_read);
    end
    tests++;
    if (cpu_rvalid !== 1'b0 || cpu_wrespvalid !== 1'b0 ||
        cpu_rdata !== 32'h0 || cpu_resp !== 2'd0 || err_unexpected_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_outs rv=%0b wv=%0b d=%h r=%0d err=%0b want zeros",
               cpu_rvalid, cpu_wrespvalid, cpu_rdata, cpu_resp, err_unexpected_o);
    end
    adv();
    cpu_read = 1'b0;
    rst_ni = 1'b1;
    mid();
    tests++;
    if (cpu_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy got %0b want 0", cpu_busy);
    end
    adv();
  endtask

  task automatic test_single_read();
    cpu_read = 1'b1;
    cpu_addr = 32'h40;
    sb.push_back('{1'b0, 32'hDEADBEEF, 2'd0});
    mid();
    tests++;
    if (avm_read !== 1'b1 || avm_address !== 32'h40 || avm_byteenable !== 4'hF) begin
      fails++;
      $display("FAIL read_issue rd=%0b a=%h be=%h want 1 40 f",
               avm_read, avm_address, avm_byteenable);
    end
    adv();
    cpu_read = 1'b0;
    mid(); adv();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hDEADBEEF;
    mid();
    tests++;
    if (cpu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL read_early rvalid=%0b want 0", cpu_rvalid);
    end
    adv();
    avm_readdatavalid = 1'b0;
    mid();
    tests++;
    if (cpu_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL read_latency rvalid=%0b want 1", cpu_rvalid);
    end
    adv();
    mid();
    tests++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF || cpu_busy !== 1'b0) begin
      fails++;
      $display("FAIL read_hold rv=%0b d=%h busy=%0b want 0 deadbeef 0",
               cpu_rvalid, cpu_rdata, cpu_busy);
    end
    adv();
  endtask

  task automatic test_write();
    cpu_write = 1'b1;
    cpu_addr = 32'h100;
    cpu_wdata = 32'h12345678;
    sb.push_back('{1'b1, 32'h0, 2'd0});
    mid();
    tests++;
    if (avm_write !== 1'b1 || avm_address !== 32'h100 || avm_writedata !== 32'h12345678) begin
      fails++;
      $display("FAIL write_issue wr=%0b a=%h d=%h want 1 100 12345678",
               avm_write, avm_address, avm_writedata);
    end
    adv();
    cpu_write = 1'b0;
    mid();
    tests++;
    if (cpu_wrespvalid !== 1'b1 || avm_write !== 1'b0 || avm_read !== 1'b0) begin
      fails++;
      $display("FAIL write_resp wv=%0b wr=%0b rd=%0b want 1 0 0",
               cpu_wrespvalid, avm_write, avm_read);
    end
    adv();
  endtask

  task automatic test_back_to_back();
    cpu_read = 1'b1;
    cpu_addr = 32'h200;
    sb.push_back('{1'b0, 32'hA1A1A1A1, 2'd0});
    mid(); adv();
    cpu_read = 1'b0;
    cpu_write = 1'b1;
    cpu_addr = 32'h204;
    sb.push_back('{1'b1, 32'h0, 2'd0});
    mid(); adv();
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    cpu_addr = 32'h208;
    sb.push_back('{1'b0, 32'hC0C0C0C0, 2'd2});
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hA1A1A1A1;
    mid();
    tests++;
    if (cpu_busy !== 1'b1 || avm_read !== 1'b0 || cpu_wrespvalid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_full busy=%0b rd=%0b wv=%0b want 1 0 0",
               cpu_busy, avm_read, cpu_wrespvalid);
    end
    adv();
    avm_readdatavalid = 1'b0;
    mid();
    tests++;
    if (cpu_rvalid !== 1'b1 || avm_read !== 1'b0) begin
      fails++;
      $display("FAIL b2b_popA rv=%0b rd=%0b want 1 0", cpu_rvalid, avm_read);
    end
    adv();
    mid();
    tests++;
    if (cpu_wrespvalid !== 1'b1 || avm_read !== 1'b1) begin
      fails++;
      $display("FAIL b2b_popB wv=%0b rd=%0b want 1 1", cpu_wrespvalid, avm_read);
    end
    adv();
    cpu_read = 1'b0;
    mid();
    tests++;
    if (cpu_rvalid !== 1'b0 || cpu_wrespvalid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_wait rv=%0b wv=%0b want 0 0", cpu_rvalid, cpu_wrespvalid);
    end
    adv();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hC0C0C0C0;
    avm_response = 2'd2;
    mid(); adv();
    avm_readdatavalid = 1'b0;
    avm_response = 2'd0;
    mid();
    tests++;
    if (cpu_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_popC rv=%0b want 1", cpu_rvalid);
    end
    adv();
  endtask

  task automatic test_waitrequest();
    avm_waitrequest = 1'b1;
    cpu_read = 1'b1;
    cpu_addr = 32'h300;
    for (int k = 0; k < 3; k++) begin
      mid();
      tests++;
      if (cpu_busy !== 1'b1) begin
        fails++;
        $display("FAIL wait_busy cyc=%0d got %0b want 1", k, cpu_busy);
      end
      adv();
    end
    avm_waitrequest = 1'b0;
    sb.push_back('{1'b0, 32'h33333333, 2'd1});
    mid(); adv();
    cpu_read = 1'b0;
    mid(); adv();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h33333333;
    avm_response = 2'd1;
    mid(); adv();
    avm_readdatavalid = 1'b0;
    avm_response = 2'd0;
    mid(); adv();
    mid();
    tests++;
    if (cpu_busy !== 1'b0 || cpu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL wait_after busy=%0b rv=%0b want 0 0", cpu_busy, cpu_rvalid);
    end
    adv();
  endtask

  task automatic test_conflict();
    cpu_read = 1'b1;
    cpu_write = 1'b1;
    cpu_addr = 32'h500;
    sb.push_back('{1'b0, 32'h55AA55AA, 2'd0});
    mid();
    tests++;
    if (avm_read !== 1'b1 || avm_write !== 1'b0) begin
      fails++;
      $display("FAIL conflict rd=%0b wr=%0b want 1 0", avm_read, avm_write);
    end
    adv();
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h55AA55AA;
    mid(); adv();
    avm_readdatavalid = 1'b0;
    mid(); adv();
    mid(); adv();
  endtask

  task automatic test_unexpected();
    avm_writeresponsevalid = 1'b1;
    mid(); adv();
    avm_writeresponsevalid = 1'b0;
    mid();
    tests++;
    if (err_unexpected_o !== 1'b0) begin
      fails++;
      $display("FAIL wresp_ignored err=%0b want 0", err_unexpected_o);
    end
    adv();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h00000BAD;
    mid(); adv();
    avm_readdatavalid = 1'b0;
    mid();
    tests++;
    if (err_unexpected_o !== 1'b1) begin
      fails++;
      $display("FAIL unexp_err err=%0b want 1", err_unexpected_o);
    end
    adv();
    for (int k = 0; k < 3; k++) begin
      mid(); adv();
    end
    mid();
    tests++;
    if (err_unexpected_o !== 1'b1) begin
      fails++;
      $display("FAIL unexp_sticky err=%0b want 1", err_unexpected_o);
    end
    adv();
    rst_ni = 1'b0;
    mid(); adv();
    rst_ni = 1'b1;
    mid();
    tests++;
    if (err_unexpected_o !== 1'b0) begin
      fails++;
      $display("FAIL unexp_clear err=%0b want 0", err_unexpected_o);
    end
    adv();
  endtask

  task automatic test_reset_midop();
    cpu_read = 1'b1;
    cpu_addr = 32'h400;
    mid(); adv();
    mid(); adv();
    cpu_read = 1'b0;
    rst_ni = 1'b0;
    mid(); adv();
    rst_ni = 1'b1;
    mid();
    tests++;
    if (err_unexpected_o !== 1'b0 || cpu_busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_clear err=%0b busy=%0b want 0 0",
               err_unexpected_o, cpu_busy);
    end
    adv();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h44444444;
    mid(); adv();
    avm_readdatavalid = 1'b0;
    mid();
    tests++;
    if (err_unexpected_o !== 1'b1 || cpu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_err err=%0b rv=%0b want 1 0",
               err_unexpected_o, cpu_rvalid);
    end
    adv();
    mid(); adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = '0;
    cpu_be = 4'hF;
    cpu_wdata = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    avm_response = 2'd0;
    avm_writeresponsevalid = 1'b0;
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_waitrequest();
    test_conflict();
    test_unexpected();
    test_reset_midop();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain left=%0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ibex_avalon_data_bridge.md
IBEX_AVALON_DATA_BRIDGE -- requirements
Module: ibex_avalon_data_bridge

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 2, meaning maximum outstanding transactions (legal 1..4).
REQ-002 SHALL have parameter AV_WRESP, default 0, meaning 1 if the Avalon slave returns writeresponsevalid, 0 if the bridge synthesizes write completions.
REQ-003 SHALL have clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni  in  1  reset, synchronous and active-low.
REQ-005 SHALL have these core-side ports: cpu_read in 1, cpu_write in 1, cpu_addr in 32, cpu_be in 4, cpu_wdata in 32; cpu_busy out 1, cpu_rvalid out 1, cpu_rdata out 32, cpu_resp out 2, cpu_wrespvalid out 1.
REQ-006 SHALL have these Avalon host ports: avm_address out 32, avm_read out 1, avm_write out 1, avm_byteenable out 4, avm_writedata out 32; avm_waitrequest in 1, avm_readdata in 32, avm_readdatavalid in 1, avm_response in 2, avm_writeresponsevalid in 1.
REQ-007 SHALL have err_unexpected_o  out  1  sticky flag: Avalon response received with no matching pending entry.

Function
REQ-008 SHALL maintain a tracker queue of MAX_OUTST entries {is_write, done, rdata[31:0], resp[1:0]}, with head/tail pointers wrapping modulo MAX_OUTST and a count 0..MAX_OUTST.
REQ-009 SHALL drive avm_read = cpu_read & ~full, and avm_write = cpu_write & ~full; address, byteenable and writedata pass through combinationally.
REQ-010 SHALL drive cpu_busy = avm_waitrequest | full, where full = (count == MAX_OUTST).
REQ-011 SHALL treat a command as accepted in any cycle with (avm_read | avm_write) & ~avm_waitrequest, and allocate the tail entry on that edge.
REQ-012 SHALL allocate a read entry with done=0. A write entry SHALL be allocated with done=1 and resp=0 when AV_WRESP=0, and with done=0 when AV_WRESP=1.
REQ-013 SHALL consume each avm_readdatavalid (and avm_writeresponsevalid when AV_WRESP=1) by completing the oldest entry with done=0. It SHALL store rdata and resp for reads, store resp only for writes, and set done.
REQ-014 SHALL assert err_unexpected_o permanently (until reset) if a response arrives with no done=0 entry, or if its type mismatches that entry; the response SHALL otherwise be dropped.
REQ-015 SHALL ignore avm_writeresponsevalid entirely when AV_WRESP=0.
REQ-016 Delivery: in each cycle where the head entry has done=1 at the start of the cycle, the bridge SHALL pulse exactly one of cpu_rvalid or cpu_wrespvalid for that cycle, drive cpu_rdata/cpu_resp from the entry, and pop it.
REQ-017 Latency: read data SHALL appear on cpu_rvalid exactly 1 cycle after avm_readdatavalid when its entry is at head; a synthesized write completion SHALL appear 1 cycle after acceptance when queue was empty.
REQ-018 SHALL deliver completions strictly in acceptance order; a completed entry behind an incomplete head SHALL wait.
REQ-019 SHALL allow simultaneous allocate, complete and pop in one cycle: count unchanged on alloc+pop; a response arriving for the head entry in the cycle it becomes head SHALL be delivered the next cycle.
REQ-020 SHALL hold cpu_rdata and cpu_resp at their last delivered values while cpu_rvalid/cpu_wrespvalid are low.
REQ-021 SHALL never issue avm_read and avm_write together; if cpu_read and cpu_write are both high, avm_write SHALL be suppressed, and the read SHALL proceed.

Reset
REQ-022 When rst_ni is low at a clock edge, the bridge SHALL clear count, pointers, all done bits and err_unexpected_o, and drive cpu_rvalid=0, cpu_wrespvalid=0, cpu_rdata=0 and cpu_resp=0 from the next cycle.
REQ-023 Reset mid-operation SHALL discard all pending entries without delivery; Avalon responses arriving after reset for pre-reset commands SHALL set err_unexpected_o.
REQ-024 While rst_ni is low, avm_read and avm_write SHALL be 0, and cpu_busy SHALL be 1.

Verification
REQ-025 Single read, readdatavalid 2 cycles after accept with readdata=32'hDEADBEEF and response=0 -> cpu_rvalid exactly 1 cycle later with cpu_rdata=32'hDEADBEEF and cpu_resp=0; count returns to 0.
REQ-026 AV_WRESP=0: write to 0x100 accepted at cycle t -> cpu_wrespvalid at t+1 with cpu_resp=0; no avm traffic after t.
REQ-027 MAX_OUTST=2: read A, write B and read C issued back-to-back; C is held (cpu_busy=1, avm_read=0) until A pops -> deliveries occur in order A(rvalid), B(wrespvalid), C(rvalid), with no overlapping pulses.
REQ-028 avm_waitrequest held high for 3 cycles during a read -> cpu_busy=1 for those 3 cycles, and exactly one entry is allocated.
REQ-029 avm_readdatavalid with an empty queue -> err_unexpected_o=1 and no cpu_rvalid; err_unexpected_o stays 1 until rst_ni is low.
REQ-030 Reset asserted with 2 reads outstanding, and one readdatavalid arriving after release -> no cpu_rvalid, and err_unexpected_o=1.
